// File: rtl/src_cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, sequencer states and instruction field layout.
package src_cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int REG_W   = 5;
    localparam int C2_W    = 17;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int IMM_BIT = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 22;
    localparam int RB_MSB  = 21;
    localparam int RB_LSB  = 17;
    localparam int RC_MSB  = 16;
    localparam int RC_LSB  = 12;
    localparam int C2_MSB  = 16;
    localparam int C2_LSB  = 0;

    typedef enum logic [3:0] {
        ALU_BTOC = 4'b0000,
        ALU_NOT  = 4'b0001,
        ALU_NEG  = 4'b0010,
        ALU_SHL  = 4'b0011,
        ALU_SHR  = 4'b0100,
        ALU_INC  = 4'b0101,
        ALU_INC4 = 4'b0110,
        ALU_ADD  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_OR   = 4'b1001,
        ALU_AND  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADA,
        ST_OPER,
        ST_WRITE
    } seq_state_e;

    typedef struct packed {
        logic [3:0]       op;
        logic             imm;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
    } instr_t;

    // Binary ops need the A operand staged through LOADA first.
    function automatic logic is_binary(input logic [3:0] op);
        return (op >= ALU_ADD) && (op <= ALU_AND);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= ALU_AND;
    endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Pure field decode of an ALU-class instruction word, including the sign-extended immediate.
module alu_instr_decode
    import src_cpu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [INSTR_W-1:0] i_instr,
    output instr_t             o_fields,
    output logic [W-1:0]       o_imm_sext,
    output logic               o_binary,
    output logic               o_legal
);

    logic [C2_W-1:0] w_c2;

    assign w_c2 = i_instr[C2_MSB:C2_LSB];

    always_comb begin
        o_fields = '{
            op:  i_instr[OP_MSB:OP_LSB],
            imm: i_instr[IMM_BIT],
            ra:  i_instr[RA_MSB:RA_LSB],
            rb:  i_instr[RB_MSB:RB_LSB],
            rc:  i_instr[RC_MSB:RC_LSB]
        };
    end

    assign o_imm_sext = {{(W-C2_W){w_c2[C2_W-1]}}, w_c2};
    assign o_binary   = is_binary(i_instr[OP_MSB:OP_LSB]);
    assign o_legal    = is_legal(i_instr[OP_MSB:OP_LSB]);

endmodule

// File: rtl/alu_step_seq.sv
// Control-step sequencer driving ALU strobes, register-file selects and the immediate bus driver.
module alu_step_seq
    import src_cpu_pkg::*;
#(
    parameter int w    = 32,
    parameter int NREG = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [INSTR_W-1:0]        instr,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal,
    output logic [3:0]                op,
    output logic                      Ain,
    output logic                      Cin,
    output logic                      Cout,
    output logic                      reg_rd_en,
    output logic [$clog2(NREG)-1:0]   reg_rd_sel,
    output logic                      reg_wr_en,
    output logic [$clog2(NREG)-1:0]   reg_wr_sel,
    inout  wire  [w-1:0]              bus
);

    localparam int SEL_W = $clog2(NREG);

    seq_state_e    r_state;
    seq_state_e    w_next;
    seq_state_e    w_start_next;
    instr_t        r_fields;
    logic [w-1:0]  r_imm_sext;
    logic          r_illegal;

    instr_t        w_dec;
    logic [w-1:0]  w_dec_sext;
    logic          w_dec_binary;
    logic          w_dec_legal;
    logic          w_accept;
    logic          w_drive_imm;

    alu_instr_decode #(.W(w)) u_decode (
        .i_instr    (instr),
        .o_fields   (w_dec),
        .o_imm_sext (w_dec_sext),
        .o_binary   (w_dec_binary),
        .o_legal    (w_dec_legal)
    );

    // A new word is taken in IDLE and in WRITE, giving zero-bubble back-to-back issue.
    assign ready    = (r_state == ST_IDLE) || (r_state == ST_WRITE);
    assign busy     = (r_state != ST_IDLE);
    assign illegal  = r_illegal;
    assign w_accept = start && ready;

    assign w_start_next = !(w_accept && w_dec_legal) ? ST_IDLE :
                          (w_dec_binary ? ST_LOADA : ST_OPER);

    // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fields   <= '0;
            r_imm_sext <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_accept && !w_dec_legal;
            if (w_accept && w_dec_legal) begin
                r_fields   <= w_dec;
                r_imm_sext <= w_dec_sext;
            end
        end
    end

    // NOTE: every output gets a default first so no branch leaves a latch behind.
    always_comb begin
        w_next      = ST_IDLE;
        op          = 4'b0000;
        Ain         = 1'b0;
        Cin         = 1'b0;
        Cout        = 1'b0;
        done        = 1'b0;
        reg_rd_en   = 1'b0;
        reg_rd_sel  = '0;
        reg_wr_en   = 1'b0;
        reg_wr_sel  = '0;
        w_drive_imm = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_next = w_start_next;
            end
            ST_LOADA: begin
                w_next     = ST_OPER;
                Ain        = 1'b1;
                reg_rd_en  = 1'b1;
                reg_rd_sel = SEL_W'(r_fields.rb);
            end
            ST_OPER: begin
                w_next = ST_WRITE;
                op     = r_fields.op;
                Cin    = 1'b1;
                if (r_fields.imm) begin
                    w_drive_imm = 1'b1;
                end else begin
                    reg_rd_en  = 1'b1;
                    reg_rd_sel = SEL_W'(r_fields.rc);
                end
            end
            ST_WRITE: begin
                w_next     = w_start_next;
                Cout       = 1'b1;
                done       = 1'b1;
                reg_wr_en  = 1'b1;
                reg_wr_sel = SEL_W'(r_fields.ra);
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Released combinationally from reset state, so an async reset frees the bus at once.
    assign bus = w_drive_imm ? r_imm_sext : {w{1'bz}};

endmodule
